// File: rtl/register_file.sv
// 32 x 32 RV32 integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, asynchronous active-low clear.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

  // Next-state for every register; entry 0 is tied to zero and never written.
  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = {DATA_WIDTH{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (WE3 && (A3 == ADDR_WIDTH'(i))) begin
        regs_d[i] = WD3;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register array state, cleared asynchronously by CLR.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: no write bypass, x0 and active clear force zero.
  always_comb begin
    RD1 = {DATA_WIDTH{1'b0}};
    RD2 = {DATA_WIDTH{1'b0}};
    if (CLR && (A1 != {ADDR_WIDTH{1'b0}})) begin
      RD1 = regs_q[A1];
    end else begin
      RD1 = {DATA_WIDTH{1'b0}};
    end
    if (CLR && (A2 != {ADDR_WIDTH{1'b0}})) begin
      RD2 = regs_q[A2];
    end else begin
      RD2 = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference register model feeds
// expected read values into a scoreboard queue, popped as the DUT reads settle.
module tb_register_file;

  logic        CLK;
  logic        CLR;
  logic        WE3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] RD1;
  logic [31:0] RD2;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int          checks;
  int          errors;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .WE3 (WE3),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .WD3 (WD3),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!CLR || a == 5'd0) return 32'h0000_0000;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0000_0000;
  endtask

  // Push both expected read values, drive addresses, then pop and compare.
  task automatic read_chk(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    exp_q.push_back(model_read(a1));
    exp_q.push_back(model_read(a2));
    A1 = a1;
    A2 = a2;
    #1;
    check_value({tag, "_rd1"}, RD1, exp_q.pop_front());
    check_value({tag, "_rd2"}, RD2, exp_q.pop_front());
  endtask

  // One write cycle; the model follows only what the DUT may legally commit.
  task automatic write_reg(input logic we, input logic [4:0] a3, input logic [31:0] wd);
    @(negedge CLK);
    WE3 = we;
    A3  = a3;
    WD3 = wd;
    @(posedge CLK);
    #1;
    if (CLR && we && a3 != 5'd0) model[a3] = wd;
    WE3 = 1'b0;
  endtask

  initial begin
    logic [4:0] addrs [5];
    logic [4:0] ra;
    logic [4:0] rb;
    checks = 0;
    errors = 0;
    addrs[0] = 5'd0; addrs[1] = 5'd1; addrs[2] = 5'd4; addrs[3] = 5'd16; addrs[4] = 5'd31;
    CLR = 1'b0; WE3 = 1'b0; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; WD3 = 32'h0000_0000;
    clear_model();

    // Reset held, then released between edges.
    repeat (3) @(negedge CLK);
    read_chk("rst_held", 5'd1, 5'd31);
    CLR = 1'b1;
    @(negedge CLK);
    foreach (addrs[i]) read_chk("reset", addrs[i], addrs[4 - i]);

    // Write disabled, x0 protection, basic write.
    write_reg(1'b0, 5'd1, 32'h0ABC_DEF0);
    read_chk("we_off", 5'd1, 5'd1);
    write_reg(1'b1, 5'd0, 32'h0ABC_DEF0);
    read_chk("x0_prot", 5'd0, 5'd0);
    write_reg(1'b1, 5'd1, 32'h0ABC_DEF0);
    read_chk("wr_r1", 5'd1, 5'd4);

    // Read-during-write on r4: old value before the edge, new right after.
    @(negedge CLK);
    A3 = 5'd4; WD3 = 32'hFFFF_FFFF; WE3 = 1'b1;
    read_chk("rdw_pre", 5'd1, 5'd4);
    @(posedge CLK);
    #1;
    model[4] = 32'hFFFF_FFFF;
    WE3 = 1'b0;
    read_chk("rdw_post", 5'd1, 5'd4);
    read_chk("rdw_a1sw", 5'd16, 5'd4);
    read_chk("r1_keep", 5'd1, 5'd4);

    // Asynchronous clear between edges, then a blocked write while held.
    @(negedge CLK);
    #2;
    CLR = 1'b0;
    clear_model();
    read_chk("async_clr", 5'd1, 5'd4);
    write_reg(1'b1, 5'd5, 32'h1234_5678);
    read_chk("clr_wr_blk", 5'd5, 5'd1);
    @(negedge CLK);
    CLR = 1'b1;
    read_chk("after_clr", 5'd5, 5'd4);

    // Randomised writes with interleaved reads against the model.
    for (int n = 0; n < 200; n++) begin
      write_reg(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                5'($urandom_range(0, 31)), $urandom);
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      read_chk("rand", ra, rb);
    end

    // Sweep every register on both ports.
    for (int i = 0; i < 32; i++) read_chk("sweep", 5'(i), 5'(31 - i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry × 32-bit general-purpose integer register file for the RISC-V RV32 CPU datapath.
- Two asynchronous (combinational) read ports: rs1 on A1/RD1, rs2 on A2/RD2.
- One synchronous write port: rd on A3/WD3/WE3.
- Register x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width; register count = 2**ADDR_WIDTH (32).

Ports:
- CLK  input  1  system clock; all writes occur on its rising edge.
- CLR  input  1  asynchronous active-low reset; 0 clears all registers.
- WE3  input  1  write enable for port 3; active-high.
- A1  input  ADDR_WIDTH  read address, port 1.
- A2  input  ADDR_WIDTH  read address, port 2.
- A3  input  ADDR_WIDTH  write address, port 3.
- WD3  input  DATA_WIDTH  write data, port 3.
- RD1  output  DATA_WIDTH  read data for A1 (combinational).
- RD2  output  DATA_WIDTH  read data for A2 (combinational).

Behaviour:
- Reset:
  - CLR=0 immediately (asynchronously, no clock needed) clears registers x0..x31 to 0x00000000.
  - While CLR=0, writes are blocked and RD1/RD2 read 0 for every address.
  - Release of CLR is sampled at the next CLK rising edge; no write occurs on the release edge unless CLR is already 1 before that edge.
- Write:
  - On CLK rising edge with CLR=1, WE3=1 and A3≠0: reg[A3] <= WD3.
  - WE3=0: no register changes, regardless of A3/WD3.
  - A3=0: write silently discarded; x0 stays 0. There is no x0 storage, or it is never written.
- Read:
  - RD1 = (A1==0) ? 0 : reg[A1]; RD2 = (A2==0) ? 0 : reg[A2].
  - Purely combinational, zero-cycle latency; reflects address changes within the same cycle.
  - Both ports may address the same register simultaneously; both return the same value.
- Read-during-write (A1 or A2 == A3, WE3=1):
  - No internal bypass.
  - RD shows the old contents until the rising edge, then the new value immediately after the edge in the same delta/timestep.
- Reset asserted mid-cycle, including coincident with a write edge: reset wins; all registers are 0.
- All address values 0..31 are valid; there is no out-of-range case.
- No handshakes, no state machine, no pipeline stages.

Test Plan:
- Reset:
  - Hold CLR=0 with WE3=0, then release.
  - RD1=RD2=0x00000000 for A1/A2 = 0, 1, 4, 16, 31.
- Write disabled:
  - CLR=1, WE3=0, A3=1, WD3=0x0ABCDEF0, one CLK edge.
  - A1=1 -> RD1=0x00000000.
- x0 protection:
  - WE3=1, A3=0, WD3=0x0ABCDEF0, one edge.
  - A1=0 -> RD1=0x00000000.
- Write and read r1:
  - WE3=1, A3=1, WD3=0x0ABCDEF0, one edge.
  - A1=1 -> RD1=0x0ABCDEF0 after the edge; r4 still reads 0.
- Read-during-write on r4:
  - A3=4, A2=4, WD3=0xFFFFFFFF, WE3=1.
  - Before the edge RD2=0x00000000; after the edge RD2=0xFFFFFFFF.
  - A1 switched to 16 -> RD1=0x00000000 immediately (combinational); r1 still 0x0ABCDEF0.
- Async reset:
  - After r1/r4 are written, drive CLR=0 between clock edges.
  - RD1 (A1=1) and RD2 (A2=4) go to 0 without a clock edge.
  - A WE3=1 edge while CLR=0 writes nothing.
